// File: rtl/mitchell_mult_pipe.sv
// Pipelined Mitchell logarithmic multiplier for signed/unsigned (N+1)-bit operands.
// Three register stages: sign/magnitude, log-domain add, antilog/sign.
// Stages hold together when the output is stalled and advance together otherwise.
// Optional build macro MITCHELL_ERRCOMP_EN adds a one-region error-compensation
// constant to the log-domain fraction when the fraction sum does not carry.
module mitchell_mult_pipe #(
    parameter int N     = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             signed_i,
    input  logic [N:0]       x_i,
    input  logic [N:0]       y_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2*N:0]     p_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int KW = $clog2(N);   // leading-one position width
    localparam int FW = N - 1;       // fraction width
    localparam int LW = KW + N;      // log-sum width (exponent gets one extra bit)
    localparam int PW = 2 * N + 1;   // product width

`ifdef MITCHELL_ERRCOMP_EN
    localparam int ERRC_SH = (N >= 5) ? (N - 5) : 0;
    // 1/16 of the fraction's unit weight; below the LSB (so nothing) when N < 5
    localparam logic [LW-1:0] ERRC = (N >= 5) ? (LW'(1) << ERRC_SH) : LW'(0);
`endif

    // |v| in N bits; the single unrepresentable value -2^N clamps to 2^N-1
    function automatic logic [N-1:0] magnitude(input logic [N:0] v, input logic is_signed);
        logic [N:0] neg;
        neg = -v;
        if (is_signed && v[N]) begin
            if (neg[N]) magnitude = '1;
            else        magnitude = neg[N-1:0];
        end else begin
            magnitude = v[N-1:0];
        end
    endfunction

    // Position of the most significant set bit (0 when m is zero)
    function automatic logic [KW-1:0] lead_one(input logic [N-1:0] m);
        lead_one = '0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) lead_one = KW'(i);
        end
    endfunction

    // Bits below the leading one, left-aligned into the fraction field
    function automatic logic [FW-1:0] frac_of(input logic [N-1:0] m, input logic [KW-1:0] k);
        logic [N-1:0] sh;
        sh = m << ((N - 1) - int'(k));
        frac_of = sh[FW-1:0];
    endfunction

    // log2(a) + log2(b) as {exponent, fraction}; fraction carry ripples into the exponent
    function automatic logic [LW-1:0] log_sum(input logic [N-1:0] ma, input logic [N-1:0] mb);
        logic [KW-1:0] ka, kb;
        logic [FW-1:0] fa, fb;
        logic [LW-1:0] sum;
`ifdef MITCHELL_ERRCOMP_EN
        logic [FW:0]   fsum;
`endif
        ka  = lead_one(ma);
        kb  = lead_one(mb);
        fa  = frac_of(ma, ka);
        fb  = frac_of(mb, kb);
        sum = {1'b0, ka, fa} + {1'b0, kb, fb};
`ifdef MITCHELL_ERRCOMP_EN
        fsum = {1'b0, fa} + {1'b0, fb};
        if (!fsum[FW]) sum = sum + ERRC;
`endif
        return sum;
    endfunction

    // 2^Lk * (1 + Lf): shift the mantissa {1,Lf} about its binary point, truncating
    function automatic logic [2*N-1:0] antilog(input logic [KW:0] lk, input logic [FW-1:0] lf);
        logic [2*N-1:0] mant;
        mant = {{N{1'b0}}, 1'b1, lf};
        if (int'(lk) >= N - 1) antilog = mant << (int'(lk) - (N - 1));
        else                   antilog = mant >> ((N - 1) - int'(lk));
    endfunction

    // Two's-complement product from magnitude, sign and zero flag
    function automatic logic signed [PW-1:0] apply_sign(input logic [2*N-1:0] mag,
                                                        input logic neg, input logic zero);
        logic signed [PW-1:0] sm;
        sm = signed'({1'b0, mag});
        if (zero)     apply_sign = '0;
        else if (neg) apply_sign = -sm;
        else          apply_sign = sm;
    endfunction

    logic                    stall, advance;
    logic                    vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
    logic                    sa_p1_q, sa_p1_d, sb_p1_q, sb_p1_d, zero_p1_q, zero_p1_d;
    logic [N-1:0]            mag_a_p1_q, mag_a_p1_d, mag_b_p1_q, mag_b_p1_d;
    logic [TAG_W-1:0]        tag_p1_q, tag_p1_d;
    logic                    sa_p2_q, sa_p2_d, sb_p2_q, sb_p2_d, zero_p2_q, zero_p2_d;
    logic [LW-1:0]           l_p2_q, l_p2_d;
    logic [TAG_W-1:0]        tag_p2_q, tag_p2_d;
    logic signed [PW-1:0]    p_q, p_d;
    logic [TAG_W-1:0]        tag_q, tag_d;

    assign stall       = vld_p3_q & ~out_ready_i;
    assign advance     = ~stall;
    assign in_ready_o  = advance;
    assign out_valid_o = vld_p3_q;
    assign p_o         = p_q;
    assign tag_o       = tag_q;
    assign busy_o      = vld_p1_q | vld_p2_q | vld_p3_q;

    // Next-state for all three stages; everything holds while stalled
    always_comb begin
        vld_p1_d   = vld_p1_q;
        sa_p1_d    = sa_p1_q;
        sb_p1_d    = sb_p1_q;
        zero_p1_d  = zero_p1_q;
        mag_a_p1_d = mag_a_p1_q;
        mag_b_p1_d = mag_b_p1_q;
        tag_p1_d   = tag_p1_q;
        vld_p2_d   = vld_p2_q;
        sa_p2_d    = sa_p2_q;
        sb_p2_d    = sb_p2_q;
        zero_p2_d  = zero_p2_q;
        l_p2_d     = l_p2_q;
        tag_p2_d   = tag_p2_q;
        vld_p3_d   = vld_p3_q;
        p_d        = p_q;
        tag_d      = tag_q;
        if (advance) begin
            // S1: sign and magnitude
            vld_p1_d = in_valid_i;
            if (in_valid_i) begin
                sa_p1_d    = signed_i & x_i[N];
                sb_p1_d    = signed_i & y_i[N];
                mag_a_p1_d = magnitude(x_i, signed_i);
                mag_b_p1_d = magnitude(y_i, signed_i);
                zero_p1_d  = (mag_a_p1_d == '0) | (mag_b_p1_d == '0);
                tag_p1_d   = tag_i;
            end
            // S2: leading-one detect, normalise, log-domain add
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                sa_p2_d   = sa_p1_q;
                sb_p2_d   = sb_p1_q;
                zero_p2_d = zero_p1_q;
                l_p2_d    = log_sum(mag_a_p1_q, mag_b_p1_q);
                tag_p2_d  = tag_p1_q;
            end
            // S3: antilog and sign; p_o keeps the last result across bubbles
            vld_p3_d = vld_p2_q;
            if (vld_p2_q) begin
                p_d   = apply_sign(antilog(l_p2_q[LW-1:FW], l_p2_q[FW-1:0]),
                                   sa_p2_q ^ sb_p2_q, zero_p2_q);
                tag_d = tag_p2_q;
            end
        end
    end

    // Stage valids and the visible output registers, cleared by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            p_q      <= '0;
            tag_q    <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            p_q      <= p_d;
            tag_q    <= tag_d;
        end
    end

    // Internal stage data, qualified by the stage valids so no reset is needed
    always_ff @(posedge clk_i) begin
        sa_p1_q    <= sa_p1_d;
        sb_p1_q    <= sb_p1_d;
        zero_p1_q  <= zero_p1_d;
        mag_a_p1_q <= mag_a_p1_d;
        mag_b_p1_q <= mag_b_p1_d;
        tag_p1_q   <= tag_p1_d;
        sa_p2_q    <= sa_p2_d;
        sb_p2_q    <= sb_p2_d;
        zero_p2_q  <= zero_p2_d;
        l_p2_q     <= l_p2_d;
        tag_p2_q   <= tag_p2_d;
    end

endmodule

// File: tb/tb_mitchell_mult_pipe.sv
// Scoreboard bench for mitchell_mult_pipe (N=8, TAG_W=4).
// Honours MITCHELL_ERRCOMP_EN for the expected values.
module tb_mitchell_mult_pipe;

    localparam int N     = 8;
    localparam int TAG_W = 4;
    localparam int PW    = 2 * N + 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             signed_i;
    logic [N:0]       x_i, y_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [PW-1:0]    p_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    mitchell_mult_pipe #(.N(N), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .signed_i(signed_i), .x_i(x_i), .y_i(y_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .p_o(p_o), .tag_o(tag_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0]    p;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Mitchell product from the arithmetic definition: log2(v) ~ k + (v-2^k)/2^k
    function automatic logic [PW-1:0] ref_mult(input bit s, input logic [N:0] x, input logic [N:0] y);
        longint F;
        longint ma, mb, ka, kb, fa, fb, lsum, lk, lf, mag, res;
        bit     sa, sb;
        F  = longint'(1) << (N - 1);
        sa = s & x[N];
        sb = s & y[N];
        ma = sa ? ((longint'(1) << (N + 1)) - longint'(x)) : longint'(x[N-1:0]);
        mb = sb ? ((longint'(1) << (N + 1)) - longint'(y)) : longint'(y[N-1:0]);
        if (ma > (longint'(1) << N) - 1) ma = (longint'(1) << N) - 1;
        if (mb > (longint'(1) << N) - 1) mb = (longint'(1) << N) - 1;
        if (ma == 0 || mb == 0) return '0;
        ka = 0;
        while ((longint'(2) << ka) <= ma) ka++;
        kb = 0;
        while ((longint'(2) << kb) <= mb) kb++;
        fa = (ma - (longint'(1) << ka)) << (N - 1 - ka);
        fb = (mb - (longint'(1) << kb)) << (N - 1 - kb);
        lsum = ka * F + fa + kb * F + fb;
`ifdef MITCHELL_ERRCOMP_EN
        if (fa + fb < F) lsum = lsum + (longint'(1) << (N - 5));
`endif
        lk  = lsum / F;
        lf  = lsum % F;
        mag = ((F + lf) << lk) >> (N - 1);
        res = (sa ^ sb) ? -mag : mag;
        return res[PW-1:0];
    endfunction

    function automatic logic [N:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return {1'b1, {N{1'b0}}};
            2:       return '1;
            3:       return {1'b0, {N{1'b1}}};
            4:       return (N+1)'(1);
            default: return (N+1)'($urandom_range(0, (1 << (N + 1)) - 1));
        endcase
    endfunction

    // Present one transaction, hold it until accepted, record its expected result
    task automatic send(input bit s, input logic [N:0] x, input logic [N:0] y,
                        input logic [TAG_W-1:0] t, input logic [PW-1:0] want, input bit rand_rdy);
        int   waited = 0;
        bit   done   = 0;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            out_ready_i = rand_rdy ? ($urandom_range(0, 9) < 7) : 1'b1;
            in_valid_i  = 1'b1;
            signed_i    = s;
            x_i         = x;
            y_i         = y;
            tag_i       = t;
            #1;
            if (in_ready_o) begin
                e.p   = want;
                e.tag = t;
                exp_q.push_back(e);
                done = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: in_ready_o stuck at %0b, required 1", in_ready_o);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid_i  = 1'b0;
            out_ready_i = 1'b1;
        end
    endtask

    // Monitor: pop and compare on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid_o && out_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: p=%0h tag=%0h with nothing outstanding", p_o, tag_o);
                end else begin
                    e = exp_q.pop_front();
                    if (p_o !== e.p || tag_o !== e.tag) begin
                        errors++;
                        $display("FAIL result: got p=%0h tag=%0h expected p=%0h tag=%0h",
                                 p_o, tag_o, e.p, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        logic [PW-1:0]    exp_55, exp_8_16, exp_clamp;
        logic [PW-1:0]    snap_p;
        logic [TAG_W-1:0] snap_tag;
        logic [N:0]       sx [6];
        logic [N:0]       sy [6];
        bit               ss [6];
        logic [N:0]       rx, ry;
        bit               rs;
        int               seen;

`ifdef MITCHELL_ERRCOMP_EN
        exp_55    = PW'(25);
        exp_8_16  = PW'(136);
        exp_clamp = -PW'(270);
`else
        exp_55    = PW'(24);
        exp_8_16  = PW'(128);
        exp_clamp = -PW'(255);
`endif

        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        signed_i = 1'b0; x_i = '0; y_i = '0; tag_i = '0;

        // Reset state
        #3;
        check("rst_out_valid", out_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_p", p_o, 0);
        check("rst_tag", tag_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        @(negedge clk);
        rst_i = 1'b0;
        idle(3);

        // Unsigned 3*3 with latency checks
        send(0, 9'd3, 9'd3, 4'd5, PW'(8), 0);
        @(negedge clk); in_valid_i = 1'b0; #1;
        check("lat_c1_valid", out_valid_o, 0);
        @(negedge clk); #1;
        check("lat_c2_valid", out_valid_o, 0);
        @(negedge clk); #1;
        check("lat_c3_valid", out_valid_o, 1);
        check("lat_c3_p", p_o, 8);
        check("lat_c3_tag", tag_o, 5);
        idle(3);

        // Directed values
        send(1, 9'h1FD, 9'd5,   4'd1, 17'h1FFF2, 0);
        send(1, 9'd0,   9'h1F9, 4'd2, PW'(0),    0);
        send(0, 9'd255, 9'd255, 4'd3, PW'(65024), 0);
        send(0, 9'd8,   9'd16,  4'd4, exp_8_16,  0);
        send(0, 9'd5,   9'd5,   4'd6, exp_55,    0);
        send(1, 9'h100, 9'd1,   4'd7, exp_clamp, 0);
        send(0, 9'h103, 9'd3,   4'd8, PW'(8),    0);
        send(1, 9'h1FF, 9'h1FF, 4'd9, PW'(1),    0);
        idle(6);

        // Back-to-back stream with a 4-cycle output hold
        for (int i = 0; i < 6; i++) begin
            ss[i] = $urandom_range(0, 1);
            sx[i] = pick_operand();
            sy[i] = pick_operand();
        end
        for (int i = 0; i < 3; i++) send(ss[i], sx[i], sy[i], TAG_W'(10 + i), ref_mult(ss[i], sx[i], sy[i]), 0);
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            out_ready_i = 1'b0;
            in_valid_i  = 1'b1;
            signed_i = ss[3]; x_i = sx[3]; y_i = sy[3]; tag_i = TAG_W'(13);
            #1;
            if (h == 0) begin
                snap_p   = p_o;
                snap_tag = tag_o;
            end
            check("hold_in_ready", in_ready_o, 0);
            check("hold_out_valid", out_valid_o, 1);
            check("hold_p_stable", p_o, snap_p);
            check("hold_tag_stable", tag_o, snap_tag);
        end
        for (int i = 3; i < 6; i++) send(ss[i], sx[i], sy[i], TAG_W'(10 + i), ref_mult(ss[i], sx[i], sy[i]), 0);
        idle(8);
        check("stream_all_delivered", exp_q.size(), 0);

        // Randomized traffic with random backpressure and gaps
        for (int i = 0; i < 300; i++) begin
            rs = $urandom_range(0, 1);
            rx = pick_operand();
            ry = pick_operand();
            send(rs, rx, ry, TAG_W'($urandom_range(0, 15)), ref_mult(rs, rx, ry), 1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid_i  = 1'b0;
                out_ready_i = $urandom_range(0, 1);
            end
        end
        @(negedge clk);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
        #2;
        check("random_drained", exp_q.size(), 0);
        idle(2);

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) send(0, 9'd7, 9'd9, TAG_W'(i), ref_mult(0, 9'd7, 9'd9), 0);
        @(posedge clk);
        #2;
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        #1;
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_p", p_o, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (out_valid_o) seen++;
        end
        check("midrst_no_stale", seen, 0);
        check("midrst_idle_busy", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
